// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing master for one display.
//   Keeps horizontal/vertical position counters and a VIS/FP/SYNC/BP phase
//   FSM per axis. Advances one pixel position per clk edge with pix_en=1.
//   All outputs are registers decoded from the next position, so they stay
//   coherent with the counters.
// Ports:
//   clk         system clock, posedge
//   rst         asynchronous active-high reset (raster parks at last position)
//   pix_en      pixel tick
//   hcount      current column, 0..H_TOTAL-1
//   vcount      current line, 0..V_TOTAL-1
//   hsync       horizontal sync, active level HSYNC_POL
//   vsync       vertical sync, active level VSYNC_POL
//   de          display enable (visible area)
//   line_start  one-clk pulse on entering hcount=0
//   frame_start one-clk pulse on entering (0,0)
module vga_timing #(
  parameter int unsigned CW        = 10,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_FP_START = CW'(H_VISIBLE);
  localparam logic [CW-1:0] H_SY_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_BP_START = CW'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_FP_START = CW'(V_VISIBLE);
  localparam logic [CW-1:0] V_SY_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_BP_START = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic [1:0] {
    PH_VIS,
    PH_FP,
    PH_SYNC,
    PH_BP
  } phase_e;

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  phase_e        hph_q, hph_d;
  phase_e        vph_q, vph_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          ls_q, ls_d;
  logic          fs_q, fs_d;
  logic          h_wrap;

  // Phase advance for one axis, keyed on the position being entered.
  function automatic phase_e next_phase(
    input phase_e        cur,
    input logic [CW-1:0] pos,
    input logic [CW-1:0] fp_start,
    input logic [CW-1:0] sy_start,
    input logic [CW-1:0] bp_start
  );
    phase_e nxt;
    nxt = cur;
    case (cur)
      PH_VIS:  if (pos == fp_start) nxt = PH_FP;
      PH_FP:   if (pos == sy_start) nxt = PH_SYNC;
      PH_SYNC: if (pos == bp_start) nxt = PH_BP;
      PH_BP:   if (pos == '0)       nxt = PH_VIS;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      hph_q   <= PH_BP;
      vph_q   <= PH_BP;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hph_q   <= hph_d;
      vph_q   <= vph_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    hph_d   = hph_q;
    vph_d   = vph_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    ls_d    = 1'b0;     // pulses self-clear on every edge, ticked or not
    fs_d    = 1'b0;
    h_wrap  = (h_q == H_LAST);

    if (pix_en) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end

      hph_d = next_phase(hph_q, h_d, H_FP_START, H_SY_START, H_BP_START);
      // Vertical phase only moves on a line wrap, so vsync changes with hcount=0.
      if (h_wrap) begin
        vph_d = next_phase(vph_q, v_d, V_FP_START, V_SY_START, V_BP_START);
      end

      hsync_d = (hph_d == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = (vph_d == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
      de_d    = (hph_d == PH_VIS) && (vph_d == PH_VIS);
      ls_d    = h_wrap;
      fs_d    = h_wrap && (v_q == V_LAST);
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing with a small raster
// (H 4/1/2/1 -> 8 columns, V 3/1/1/1 -> 6 lines, active-low syncs).
// The reference model tracks a linear pixel index within the frame and
// derives every output from it arithmetically.
module tb_vga_timing;

  localparam int CW      = 10;
  localparam int H_TOT   = 8;
  localparam int V_TOT   = 6;
  localparam int F_TOT   = H_TOT * V_TOT;

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          de;
    logic          hs;
    logic          vs;
    logic          ls;
    logic          fs;
  } obs_t;

  logic          clk;
  logic          rst;
  logic          pix_en;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          line_start;
  logic          frame_start;

  int   checks   = 0;
  int   failures = 0;
  int   pos;
  obs_t exp_q[$];
  bit   stim_done = 0;

  vga_timing #(
    .CW(CW),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_en(pix_en),
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs at frame index p; ticked = an advance just happened.
  function automatic obs_t model(input int p, input bit ticked);
    obs_t e;
    int h, v;
    h = p % H_TOT;
    v = p / H_TOT;
    e.h  = CW'(h);
    e.v  = CW'(v);
    e.de = (h < 4) && (v < 3);
    e.hs = !((h >= 5) && (h < 7));
    e.vs = !((v >= 4) && (v < 5));
    e.ls = ticked && (h == 0);
    e.fs = ticked && (p == 0);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a = '{h: hcount, v: vcount, de: de, hs: hsync, vs: vsync,
          ls: line_start, fs: frame_start};
    return a;
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t act h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b exp h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               name, $time, act.h, act.v, act.de, act.hs, act.vs, act.ls, act.fs,
               exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.ls, exp.fs);
    end
  endtask

  // One clk of stimulus; expectation for that edge goes to the scoreboard.
  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clk);
    if (rst) begin
      pos = F_TOT - 1;
      exp_q.push_back(model(pos, 1'b0));
    end else begin
      if (en) pos = (pos + 1) % F_TOT;
      exp_q.push_back(model(pos, en));
    end
    #1;
  endtask

  // Asynchronous reset between edges, checked before any clk edge.
  task automatic async_reset(input string name);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    compare(name, sample(), model(F_TOT - 1, 1'b0));
    pos = F_TOT - 1;
    repeat (2) tick(1'($urandom_range(0, 1)));
    rst = 1'b0;
  endtask

  // Monitor: outputs are presented every clk, checked mid-cycle.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare("scoreboard", sample(), e);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    pos    = F_TOT - 1;
    #2;
    compare("reset_no_clk", sample(), model(F_TOT - 1, 1'b0));
    repeat (3) tick(1'($urandom_range(0, 1)));
    rst = 1'b0;

    // First tick lands on (0,0) with both pulses, then pulses drop.
    tick(1);
    tick(0);
    tick(0);

    // Free run: a bit over two frames.
    repeat (2 * F_TOT + 10) tick(1);

    // Every third clk.
    for (int i = 0; i < 3 * F_TOT; i++) tick(i % 3 == 0);

    // Random enable density.
    for (int i = 0; i < 400; i++) tick(($urandom % 4) != 0);

    // Reset at (h=2, v=1), bounded search.
    for (int i = 0; i < 3 * F_TOT && pos != 10; i++) tick(1);
    checks++;
    if (pos != 10) begin
      failures++;
      $display("FAIL seek_h2v1 act pos=%0d exp pos=10", pos);
    end
    async_reset("reset_mid_frame");
    tick(1);
    tick(1);

    // Random reset points interleaved with random running.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(5, 90)) tick(1'($urandom_range(0, 1)));
      async_reset("reset_random");
      repeat (20) tick(1'($urandom_range(0, 1)));
    end

    repeat (F_TOT + 5) tick(1);
    pix_en = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain act pending=%0d exp pending=0", exp_q.size());
    end
    stim_done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2000000;
    if (!stim_done) begin
      $display("FAIL timeout act running exp finished");
      $fatal(1, "timeout");
    end
  end

endmodule
